// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package instr_fetch_unit_pkg;

    localparam int          DEF_DATA_WIDTH     = 32;
    localparam int          DEF_RAM_ADDR_WIDTH = 12;
    localparam int          DEF_FIFO_DEPTH     = 2;
    localparam logic [31:0] DEF_RESET_PC       = 32'h0000_0000;

    // Every instruction is one 32-bit word, so the PC advances in steps of 4.
    localparam int          INSTR_BYTES        = 4;

    // One idle BOOT cycle after reset, then RUN forever.
    typedef enum logic {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous queue of {instr, pc} pairs. Flush beats push and pop;
// push and pop may coincide at any occupancy.
module fetch_fifo #(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 2,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_full;
    logic                  w_do_push;
    logic                  w_do_pop;

    // Pointers wrap explicitly so depths that are not a power of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A push into a full queue only lands when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_instr   = r_instr_mem[r_rd_ptr];
    assign o_pc      = r_pc_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // NOTE: the storage is reset (only a few entries) so the head outputs read 0, not X, after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_instr_mem[r_wr_ptr] <= i_instr;
                r_pc_mem[r_wr_ptr]    <= i_pc;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues one BRAM read per cycle under a
// credit rule, queues returned words and hands {instr, instr_pc} to decode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int                    RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
    parameter int                    FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = DATA_WIDTH'(DEF_RESET_PC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic [RAM_ADDR_WIDTH-1:0] i_r_addr,
    output logic                      i_r_enb,
    input  logic [DATA_WIDTH-1:0]     i_r_dat,
    output logic                      instr_valid,
    output logic [DATA_WIDTH-1:0]     instr,
    output logic [DATA_WIDTH-1:0]     instr_pc,
    input  logic                      instr_ready
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    // Queued plus in-flight words can reach FIFO_DEPTH + 1 before a pop is subtracted.
    localparam int CRED_W = $clog2(FIFO_DEPTH + 2);

    fetch_state_e          r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_tag_pc;
    logic                  r_inflight;

    logic [CNT_W-1:0]      w_count;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [CRED_W-1:0]     w_credit;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    // Redirect targets are forced onto a word boundary.
    assign w_redirect_pc = redirect_pc & ~DATA_WIDTH'(INSTR_BYTES - 1);

    // A redirect swallows any pop and any response arriving in the same cycle.
    assign instr_valid = ~w_empty;
    assign w_pop       = instr_valid & instr_ready & ~redirect_valid;
    assign w_push      = r_inflight & ~redirect_valid;

    // Issue only if the word still fits once everything already owed has landed.
    assign w_credit = CRED_W'(w_count) + CRED_W'(r_inflight) - CRED_W'(w_pop);
    assign w_issue  = (r_state == FETCH_RUN) & ~redirect_valid
                    & (w_credit < CRED_W'(FIFO_DEPTH));

    assign i_r_enb  = w_issue;
    assign i_r_addr = r_pc[RAM_ADDR_WIDTH-1:0];

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_instr (i_r_dat),
        .i_pc    (r_tag_pc),
        .i_pop   (w_pop),
        .o_instr (instr),
        .o_pc    (instr_pc),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // FSM, fetch PC and in-flight tag: redirect outranks issue, issue advances the PC.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and all state uses <=.
        if (!rst) begin
            r_state    <= FETCH_BOOT;
            r_pc       <= RESET_PC;
            r_tag_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                FETCH_BOOT: r_state <= FETCH_RUN;
                default:    r_state <= FETCH_RUN;
            endcase

            if (redirect_valid) begin
                r_pc       <= w_redirect_pc;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc     <= r_pc + DATA_WIDTH'(INSTR_BYTES);
                    r_tag_pc <= r_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: BRAM model, scoreboard of expected {pc, instr}
// filled when the fetch stream is (re)started, popped on every accepted word.
module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] i_r_addr;
    logic        i_r_enb;
    logic [31:0] i_r_dat;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int   n_total;
    int   n_pass;
    bit   overflow_seen;
    exp_t sb[$];
    exp_t e;

    instr_fetch_unit #(
        .DATA_WIDTH     (32),
        .RAM_ADDR_WIDTH (12),
        .FIFO_DEPTH     (2),
        .RESET_PC       (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .i_r_addr       (i_r_addr),
        .i_r_enb        (i_r_enb),
        .i_r_dat        (i_r_dat),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Address-dependent contents so a wrong word or wrong tag is visible.
    function automatic logic [31:0] bram_word(input logic [11:0] a);
        return {a, 4'h5, ~a, 4'hA};
    endfunction

    // BRAM with one cycle of read latency.
    initial i_r_dat = '0;
    always @(posedge clk) begin
        if (i_r_enb === 1'b1) i_r_dat <= bram_word(i_r_addr);
    end

    // Expected stream from a new start PC.
    task automatic sb_restart(input logic [31:0] start_pc);
        logic [31:0] p;
        sb.delete();
        p = start_pc;
        for (int k = 0; k < 64; k++) begin
            sb.push_back('{pc: p, instr: bram_word(p[11:0])});
            p = p + 32'd4;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) sb_restart(rpc & ~32'd3);
        #1;
    endtask

    // Scoreboard: every word decode accepts at the next rising edge must be the expected one.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect_valid === 1'b0) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no output", instr_pc, instr);
            end else begin
                e = sb.pop_front();
                if (instr_pc !== e.pc || instr !== e.instr)
                    $display("FAIL sb_stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                             instr_pc, instr, e.pc, e.instr);
                else n_pass++;
            end
        end
        if (rst === 1'b1 && dut.u_fifo.i_push === 1'b1 && dut.u_fifo.w_full === 1'b1
            && dut.u_fifo.i_pop !== 1'b1 && dut.u_fifo.i_flush !== 1'b1)
            overflow_seen = 1'b1;
    end

    task automatic test_reset();
        rst = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL reset_enb: got %b expected 0", i_r_enb); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr); else n_pass++;
        n_total++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); else n_pass++;
        n_total++; if (i_r_addr !== 12'h000) $display("FAIL reset_addr: got %h expected 000", i_r_addr); else n_pass++;
    endtask

    task automatic test_sequential();
        @(negedge clk);
        rst = 1'b1; instr_ready = 1'b1;
        sb_restart(32'h0);
        #1;
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL boot_enb: got %b expected 0", i_r_enb); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            tick(1'b1, 1'b0, '0);
            n_total++; if (i_r_enb !== 1'b1) $display("FAIL seq_enb[%0d]: got %b expected 1", c, i_r_enb); else n_pass++;
            n_total++; if (i_r_addr !== 12'((c - 1) * 4)) $display("FAIL seq_addr[%0d]: got %h expected %h", c, i_r_addr, 12'((c - 1) * 4)); else n_pass++;
            n_total++; if (instr_valid !== (c == 3)) $display("FAIL seq_valid[%0d]: got %b expected %b", c, instr_valid, c == 3); else n_pass++;
        end
        n_total++; if (instr_pc !== 32'h0) $display("FAIL seq_first_pc: got %h expected 0", instr_pc); else n_pass++;
        n_total++; if (instr !== bram_word(12'h000)) $display("FAIL seq_first_instr: got %h expected %h", instr, bram_word(12'h000)); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, 1'b0, '0);
            n_total++; if (instr_valid !== 1'b1) $display("FAIL seq_throughput[%0d]: got %b expected 1", c, instr_valid); else n_pass++;
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 1'b0, '0);
            n_total++; if (i_r_enb !== 1'b0) $display("FAIL stall_enb[%0d]: got %b expected 0", c, i_r_enb); else n_pass++;
            n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", c, instr_valid); else n_pass++;
        end
        tick(1'b1, 1'b0, '0);
        n_total++; if (i_r_enb !== 1'b1) $display("FAIL stall_release_enb: got %b expected 1", i_r_enb); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            tick(1'b1, 1'b0, '0);
            n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_resume_valid[%0d]: got %b expected 1", c, instr_valid); else n_pass++;
        end
    endtask

    // Shared tail for redirect scenarios: new stream appears exactly 3 cycles after the redirect.
    task automatic expect_redirect_latency(input string name, input logic [31:0] target);
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b0) $display("FAIL %s_valid1: got %b expected 0", name, instr_valid); else n_pass++;
        n_total++; if (i_r_enb !== 1'b1 || i_r_addr !== target[11:0]) $display("FAIL %s_addr1: got enb=%b addr=%h expected enb=1 addr=%h", name, i_r_enb, i_r_addr, target[11:0]); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b0) $display("FAIL %s_valid2: got %b expected 0", name, instr_valid); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== target) $display("FAIL %s_first: got valid=%b pc=%h expected valid=1 pc=%h", name, instr_valid, instr_pc, target); else n_pass++;
    endtask

    task automatic test_redirect();
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 32'h100);
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL redir_enb: got %b expected 0", i_r_enb); else n_pass++;
        expect_redirect_latency("redir", 32'h100);
    endtask

    task automatic test_redirect_pop();
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 32'h103);
        n_total++; if (instr_valid !== 1'b1) $display("FAIL redir_pop_head: got %b expected 1", instr_valid); else n_pass++;
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL redir_pop_enb: got %b expected 0", i_r_enb); else n_pass++;
        expect_redirect_latency("redir_pop", 32'h100);
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b1, 32'h200);
        tick(1'b1, 1'b1, 32'h300);
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL b2b_enb: got %b expected 0", i_r_enb); else n_pass++;
        expect_redirect_latency("b2b", 32'h300);
        for (int c = 0; c < 4; c++) tick(1'b1, 1'b0, '0);
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b1, 32'hFF8);
        tick(1'b1, 1'b0, '0);
        n_total++; if (i_r_addr !== 12'hFF8) $display("FAIL wrap_addr0: got %h expected ff8", i_r_addr); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (i_r_addr !== 12'hFFC) $display("FAIL wrap_addr1: got %h expected ffc", i_r_addr); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (i_r_enb !== 1'b1 || i_r_addr !== 12'h000) $display("FAIL wrap_addr2: got enb=%b addr=%h expected enb=1 addr=000", i_r_enb, i_r_addr); else n_pass++;
        n_total++; if (instr_pc !== 32'hFF8) $display("FAIL wrap_pc0: got %h expected ff8", instr_pc); else n_pass++;
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000) $display("FAIL wrap_pc2: got valid=%b pc=%h expected valid=1 pc=00001000", instr_valid, instr_pc); else n_pass++;
        n_total++; if (instr !== bram_word(12'h000)) $display("FAIL wrap_instr2: got %h expected %h", instr, bram_word(12'h000)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, '0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        sb_restart(32'h0);
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", instr_valid); else n_pass++;
        n_total++; if (i_r_enb !== 1'b0) $display("FAIL rstmid_enb: got %b expected 0", i_r_enb); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (i_r_enb !== 1'b1 || i_r_addr !== 12'h000) $display("FAIL rstmid_addr: got enb=%b addr=%h expected enb=1 addr=000", i_r_enb, i_r_addr); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rstmid_stale: got %b expected 0", instr_valid); else n_pass++;
        tick(1'b1, 1'b0, '0);
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL rstmid_first: got valid=%b pc=%h expected valid=1 pc=0", instr_valid, instr_pc); else n_pass++;
        for (int c = 0; c < 6; c++) tick(1'b1, 1'b0, '0);
        n_total++; if (overflow_seen !== 1'b0) $display("FAIL queue_overflow: got %b expected 0", overflow_seen); else n_pass++;
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        overflow_seen = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
